register_dump_unit: RTL and testbench

Debug-side reader for the register bank. It dumps the full register bank as a byte stream for the debug UART path. On a start pulse it walks register addresses 0..BANK_SIZE-1 and captures each word from the bank's read port. It serialises each word MSB-byte-first over a valid/ready byte interface to the UART transmitter. It sits between the debug controller, the register bank's second read port and the UART TX.

---
 rtl/register_dump_unit_pkg.sv | 23 ++
 rtl/register_dump_unit_if.sv | 28 ++
 rtl/register_dump_unit.sv | 94 +++++++++
 tb/tb_register_dump_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_dump_unit_pkg.sv
// Shared debug-dump definitions: FSM encoding, word/byte geometry and byte order.
// Also used by the memory dump unit and the host-side decoder.
package register_dump_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    // Dump streams send the most significant byte of each word first.
    localparam bit DUMP_MSB_FIRST = 1'b1;

    localparam int DEFAULT_DATA_LENGTH    = 32;
    localparam int DEFAULT_BYTE_WIDTH     = 8;
    localparam int DEFAULT_BYTES_PER_WORD = DEFAULT_DATA_LENGTH / DEFAULT_BYTE_WIDTH;

    function automatic int bytes_per_word(input int data_length, input int byte_width);
        return data_length / byte_width;
    endfunction

endpackage

// File: rtl/register_dump_unit_if.sv
// Register-bank read port plus byte-stream handshake between dump unit and UART TX.
interface register_dump_unit_if #(
    parameter int ADDR_LENGTH = 5,
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_WIDTH  = 8
);
    logic [ADDR_LENGTH-1:0] reg_addr;
    logic [DATA_LENGTH-1:0] reg_data;
    logic [BYTE_WIDTH-1:0]  tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (
        output reg_addr,
        input  reg_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  reg_addr,
        output reg_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/register_dump_unit.sv
// Walks the register bank on a start pulse and streams every word as bytes
// over a valid/ready interface; one LOAD bubble separates consecutive words.
module register_dump_unit
    import register_dump_unit_pkg::*;
#(
    parameter int BANK_SIZE   = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    register_dump_unit_if.master bus,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BPW   = bytes_per_word(DATA_LENGTH, BYTE_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [CNT_W-1:0]       LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(BANK_SIZE - 1);

    dump_state_e            state_reg, state_next;
    logic [ADDR_LENGTH-1:0] addr_reg,  addr_next;
    logic [DATA_LENGTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]       cnt_reg,   cnt_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_LOAD;
                    addr_next  = '0;
                end
            end
            ST_LOAD: begin
                // Bank is frozen by the debug controller, so one capture is safe.
                shift_next = bus.reg_data;
                cnt_next   = '0;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    shift_next = DUMP_MSB_FIRST ? (shift_reg << BYTE_WIDTH)
                                                : (shift_reg >> BYTE_WIDTH);
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BYTE) begin
                        if (addr_reg == LAST_ADDR) begin
                            state_next = ST_DONE;
                            addr_next  = '0;
                        end else begin
                            state_next = ST_LOAD;
                            addr_next  = addr_reg + ADDR_LENGTH'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.reg_addr = addr_reg;
    assign bus.tx_valid = (state_reg == ST_SEND);
    assign bus.tx_data  = DUMP_MSB_FIRST ? shift_reg[DATA_LENGTH-1 -: BYTE_WIDTH]
                                         : shift_reg[BYTE_WIDTH-1:0];
    assign o_busy       = (state_reg == ST_LOAD) || (state_reg == ST_SEND);
    assign o_done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_register_dump_unit.sv
// Scoreboard bench for register_dump_unit: default build plus a 4x16-bit build.
module tb_register_dump_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic ready = 1'b1;
    logic busy, done, busy2, done2;

    always #5 clk = ~clk;

    register_dump_unit_if #(.ADDR_LENGTH(5), .DATA_LENGTH(32), .BYTE_WIDTH(8)) bus ();
    register_dump_unit_if #(.ADDR_LENGTH(2), .DATA_LENGTH(16), .BYTE_WIDTH(8)) bus2 ();

    logic [31:0] bank [32];
    logic [15:0] bank2 [4];

    assign bus.reg_data  = bank[bus.reg_addr];
    assign bus.tx_ready  = ready;
    assign bus2.reg_data = bank2[bus2.reg_addr];
    assign bus2.tx_ready = 1'b1;

    register_dump_unit #(.BANK_SIZE(32), .ADDR_LENGTH(5), .DATA_LENGTH(32), .BYTE_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .bus(bus), .o_busy(busy), .o_done(done)
    );

    register_dump_unit #(.BANK_SIZE(4), .ADDR_LENGTH(2), .DATA_LENGTH(16), .BYTE_WIDTH(8)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .bus(bus2), .o_busy(busy2), .o_done(done2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int peak2    = 0;
    int start_cyc = 0;
    bit watch_lat = 1'b0;
    bit seen_first = 1'b0;
    bit rdy_rand = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    // Expected stream for bank[i] = 0x01020300+i, optionally with reg 5 = DEADBEEF.
    task automatic push_std(input bit dead5);
        for (int i = 0; i < 32; i++) begin
            if (dead5 && i == 5) push_word(8'hDE, 8'hAD, 8'hBE, 8'hEF);
            else                 push_word(8'h01, 8'h02, 8'h03, 8'(i));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int base;
        int k;
        base = done_cnt;
        k = 0;
        while (done_cnt == base && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
        check({name, "_done_once"}, 32'(done_cnt - base), 32'd1);
        check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // Monitor for the default build.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_busy;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.tx_valid), 32'd1);
                    check("hold_data", 32'(bus.tx_data), 32'(prev_data));
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_byte: got %02h, expected no byte (cycle %0d)", bus.tx_data, cyc);
                    end else begin
                        check("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (watch_lat && bus.tx_valid && !seen_first) begin
                    seen_first = 1'b1;
                    check("first_valid_latency", 32'(cyc - start_cyc), 32'd2);
                end
                if (done) begin
                    done_cnt++;
                    check("busy_low_at_done", 32'(busy), 32'd0);
                    check("busy_high_before_done", 32'(prev_busy), 32'd1);
                    if (watch_lat) check("done_latency", 32'(cyc - start_cyc), 32'd161);
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data  = bus.tx_data;
            end
            prev_busy = busy;
        end
    end

    // Monitor for the 4 x 16-bit build; its ready is tied high.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus2.tx_valid) begin
                if (exp2_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL small_extra_byte: got %02h, expected no byte (cycle %0d)", bus2.tx_data, cyc);
                end else begin
                    check("small_byte", 32'(bus2.tx_data), 32'(exp2_q.pop_front()));
                end
            end
            if (int'(bus2.reg_addr) > peak2) peak2 = int'(bus2.reg_addr);
            if (done2) done2_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] small_bytes [8];
        int dbase;
        int k;

        for (int i = 0; i < 32; i++) bank[i] = 32'h0102_0300 + 32'(i);
        for (int i = 0; i < 4; i++) bank2[i] = {8'hA1, 8'hB0 + 8'(i)};

        // Reset state, then quiet idle with no start.
        tick(2);
        check("reset_state", 32'({bus.tx_valid, busy, done, bus.reg_addr, bus.tx_data}), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick(1);
        for (int i = 0; i < 100; i++) begin
            check("idle_quiet", 32'({bus.tx_valid, busy, done, bus.reg_addr}), 32'd0);
            tick(1);
        end

        // Full dump with ready high; start during DONE must be ignored.
        push_std(1'b0);
        watch_lat = 1'b1;
        seen_first = 1'b0;
        dbase = done_cnt;
        start = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
        while (cyc < start_cyc + 161) tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("t1_done_once", 32'(done_cnt - dbase), 32'd1);
        check("t1_all_bytes", 32'(exp_q.size()), 32'd0);
        watch_lat = 1'b0;
        tick(10);
        check("t1_start_in_done_ignored", 32'({busy, bus.tx_valid}), 32'd0);
        check("t1_no_second_done", 32'(done_cnt - dbase), 32'd1);
        check("t1_addr_back_to_zero", 32'(bus.reg_addr), 32'd0);

        // Random backpressure with reg 5 = DEADBEEF.
        bank[5] = 32'hDEAD_BEEF;
        push_std(1'b1);
        rdy_rand = 1'b1;
        pulse_start();
        wait_done(3000, "t2");
        rdy_rand = 1'b0;
        bank[5] = 32'h0102_0305;
        tick(2);

        // Repeated start pulses during a dump, then an identical second dump.
        push_std(1'b0);
        dbase = done_cnt;
        pulse_start();
        tick(20);
        pulse_start();
        tick(30);
        pulse_start();
        tick(40);
        pulse_start();
        wait_done(400, "t3a");
        tick(10);
        check("t3_single_done", 32'(done_cnt - dbase), 32'd1);
        push_std(1'b0);
        pulse_start();
        wait_done(400, "t3b");

        // Asynchronous reset in the middle of word 10.
        push_std(1'b0);
        pulse_start();
        k = 0;
        while (!(bus.reg_addr == 5'd10 && bus.tx_valid) && k < 400) begin
            tick(1);
            k++;
        end
        check("t4_reached_word10", 32'(bus.reg_addr), 32'd10);
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("t4_async_valid", 32'(bus.tx_valid), 32'd0);
        check("t4_async_busy", 32'(busy), 32'd0);
        check("t4_async_addr", 32'(bus.reg_addr), 32'd0);
        exp_q.delete();
        dbase = done_cnt;
        @(negedge clk);
        #1 rst = 1'b0;
        tick(5);
        check("t4_no_done", 32'(done_cnt - dbase), 32'd0);
        check("t4_idle_after_reset", 32'({busy, bus.tx_valid}), 32'd0);
        push_std(1'b0);
        pulse_start();
        wait_done(400, "t4_restart");

        // Small build: 4 registers of 16 bits.
        small_bytes = '{8'hA1, 8'hB0, 8'hA1, 8'hB1, 8'hA1, 8'hB2, 8'hA1, 8'hB3};
        for (int i = 0; i < 8; i++) exp2_q.push_back(small_bytes[i]);
        peak2 = 0;
        dbase = done2_cnt;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        k = 0;
        while (done2_cnt == dbase && k < 100) begin
            tick(1);
            k++;
        end
        tick(2);
        check("t6_done_once", 32'(done2_cnt - dbase), 32'd1);
        check("t6_all_bytes", 32'(exp2_q.size()), 32'd0);
        check("t6_peak_addr", 32'(peak2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
